// File: rtl/id_pkg.sv
// Shared decode definitions for the ID stage: opcodes, EXE/branch/memory codes,
// the control bundle and the opcode decoder.
package id_pkg;

  localparam logic [5:0] OP_NOP  = 6'd0;
  localparam logic [5:0] OP_ADD  = 6'd1;
  localparam logic [5:0] OP_SUB  = 6'd3;
  localparam logic [5:0] OP_AND  = 6'd5;
  localparam logic [5:0] OP_OR   = 6'd6;
  localparam logic [5:0] OP_NOR  = 6'd7;
  localparam logic [5:0] OP_XOR  = 6'd8;
  localparam logic [5:0] OP_SLA  = 6'd9;
  localparam logic [5:0] OP_SLL  = 6'd10;
  localparam logic [5:0] OP_SRA  = 6'd11;
  localparam logic [5:0] OP_SRL  = 6'd12;
  localparam logic [5:0] OP_ADDI = 6'd32;
  localparam logic [5:0] OP_SUBI = 6'd33;
  localparam logic [5:0] OP_LD   = 6'd36;
  localparam logic [5:0] OP_ST   = 6'd37;
  localparam logic [5:0] OP_BEZ  = 6'd40;
  localparam logic [5:0] OP_BNE  = 6'd41;
  localparam logic [5:0] OP_JMP  = 6'd42;

  localparam logic [3:0] EXE_ADD = 4'b0000;
  localparam logic [3:0] EXE_SUB = 4'b0010;
  localparam logic [3:0] EXE_AND = 4'b0100;
  localparam logic [3:0] EXE_OR  = 4'b0101;
  localparam logic [3:0] EXE_NOR = 4'b0110;
  localparam logic [3:0] EXE_XOR = 4'b0111;
  localparam logic [3:0] EXE_SLL = 4'b1000;
  localparam logic [3:0] EXE_SRA = 4'b1001;
  localparam logic [3:0] EXE_SRL = 4'b1010;

  localparam logic [1:0] BR_NONE = 2'b00;
  localparam logic [1:0] BR_BEZ  = 2'b01;
  localparam logic [1:0] BR_BNE  = 2'b10;
  localparam logic [1:0] BR_JMP  = 2'b11;

  localparam logic [1:0] MEM_NONE = 2'b00;
  localparam logic [1:0] MEM_RD   = 2'b10;
  localparam logic [1:0] MEM_WR   = 2'b01;

  typedef struct packed {
    logic       wb;
    logic [1:0] mem;
    logic [1:0] br;
    logic [3:0] cmd;
    logic       is_imm;
    logic       uses_rt;
  } ctrl_t;

  // Register-register ALU op: writes back and reads rt.
  function automatic ctrl_t alu_rr(input logic [3:0] cmd);
    ctrl_t c;
    c = '0;
    c.wb      = 1'b1;
    c.cmd     = cmd;
    c.uses_rt = 1'b1;
    return c;
  endfunction

  function automatic ctrl_t decode(input logic [5:0] op);
    ctrl_t c;
    c = '0;
    case (op)
      OP_ADD:  c = alu_rr(EXE_ADD);
      OP_SUB:  c = alu_rr(EXE_SUB);
      OP_AND:  c = alu_rr(EXE_AND);
      OP_OR:   c = alu_rr(EXE_OR);
      OP_NOR:  c = alu_rr(EXE_NOR);
      OP_XOR:  c = alu_rr(EXE_XOR);
      OP_SLA,
      OP_SLL:  c = alu_rr(EXE_SLL);
      OP_SRA:  c = alu_rr(EXE_SRA);
      OP_SRL:  c = alu_rr(EXE_SRL);
      OP_ADDI: begin c.wb = 1'b1; c.cmd = EXE_ADD; c.is_imm = 1'b1; end
      OP_SUBI: begin c.wb = 1'b1; c.cmd = EXE_SUB; c.is_imm = 1'b1; end
      OP_LD:   begin c.wb = 1'b1; c.mem = MEM_RD; c.is_imm = 1'b1; end
      OP_ST:   begin c.mem = MEM_WR; c.is_imm = 1'b1; c.uses_rt = 1'b1; end
      OP_BEZ:  begin c.br = BR_BEZ; c.is_imm = 1'b1; end
      OP_BNE:  begin c.br = BR_BNE; c.is_imm = 1'b1; c.uses_rt = 1'b1; end
      OP_JMP:  begin c.br = BR_JMP; c.is_imm = 1'b1; end
      default: c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/regfile_bypass.sv
// Two-read one-write register file with same-cycle write-through bypass.
// Indices at or above NREGS read 0 and drop writes; R0 is constant 0 when R0_ZERO.
module regfile_bypass #(
  parameter int XLEN    = 32,
  parameter int NREGS   = 32,
  parameter int R0_ZERO = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [4:0]      i_rd_idx_a,
  input  logic [4:0]      i_rd_idx_b,
  input  logic            i_wr_en,
  input  logic [4:0]      i_wr_idx,
  input  logic [XLEN-1:0] i_wr_data,
  output logic [XLEN-1:0] o_rd_a,
  output logic [XLEN-1:0] o_rd_b
);

  logic [XLEN-1:0] r_regs [32];

  // True for indices that hold real, writable state.
  function automatic logic idx_live(input logic [4:0] idx);
    return ({1'b0, idx} < 6'(NREGS)) && !((R0_ZERO != 0) && (idx == 5'd0));
  endfunction

  function automatic logic [XLEN-1:0] rd_port(input logic [4:0] idx, input logic wr_en,
                                              input logic [4:0] wr_idx,
                                              input logic [XLEN-1:0] wr_data,
                                              input logic [XLEN-1:0] stored);
    if (!idx_live(idx)) return '0;
    if (wr_en && (wr_idx == idx)) return wr_data;
    return stored;
  endfunction

  assign o_rd_a = rd_port(i_rd_idx_a, i_wr_en, i_wr_idx, i_wr_data, r_regs[i_rd_idx_a]);
  assign o_rd_b = rd_port(i_rd_idx_b, i_wr_en, i_wr_idx, i_wr_data, r_regs[i_rd_idx_b]);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) r_regs[i] <= XLEN'(i);
    end else if (i_wr_en && idx_live(i_wr_idx)) begin
      r_regs[i_wr_idx] <= i_wr_data;
    end
  end

endmodule

// File: rtl/id_stage_pipe.sv
// Instruction-decode stage with register file, load-use hazard detection and
// the ID/EX pipeline register feeding EXE.
module id_stage_pipe
  import id_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int NREGS   = 32,
  parameter int R0_ZERO = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [31:0]     instr_i,
  input  logic [XLEN-1:0] pc_i,
  input  logic            freeze_i,
  input  logic            flush_i,
  input  logic            wb_en_i,
  input  logic [4:0]      wb_dest_i,
  input  logic [XLEN-1:0] wb_data_i,
  output logic            stall_o,
  output logic            valid_o,
  output logic            wb_en_o,
  output logic [1:0]      mem_sig_o,
  output logic [1:0]      br_type_o,
  output logic [3:0]      exe_cmd_o,
  output logic [XLEN-1:0] val1_o,
  output logic [XLEN-1:0] val2_o,
  output logic [XLEN-1:0] st_val_o,
  output logic [XLEN-1:0] pc_o,
  output logic [4:0]      dest_o,
  output logic [4:0]      src1_o,
  output logic [4:0]      src2_o
);

  logic [5:0]      w_op;
  logic [4:0]      w_rs;
  logic [4:0]      w_rt;
  logic [4:0]      w_rd;
  logic [15:0]     w_imm16;
  logic [XLEN-1:0] w_imm_ext;
  logic [XLEN-1:0] w_rs_val;
  logic [XLEN-1:0] w_rt_val;
  ctrl_t           w_ctrl;
  logic            w_hz;
  logic            w_bubble;

  assign w_op      = instr_i[31:26];
  assign w_rs      = instr_i[25:21];
  assign w_rt      = instr_i[20:16];
  assign w_rd      = instr_i[15:11];
  assign w_imm16   = instr_i[15:0];
  assign w_imm_ext = {{(XLEN-16){w_imm16[15]}}, w_imm16};
  assign w_ctrl    = decode(w_op);

  regfile_bypass #(
    .XLEN    (XLEN),
    .NREGS   (NREGS),
    .R0_ZERO (R0_ZERO)
  ) u_rf (
    .clk        (clk),
    .rst        (rst),
    .i_rd_idx_a (w_rs),
    .i_rd_idx_b (w_rt),
    .i_wr_en    (wb_en_i),
    .i_wr_idx   (wb_dest_i),
    .i_wr_data  (wb_data_i),
    .o_rd_a     (w_rs_val),
    .o_rd_b     (w_rt_val)
  );

  // Load in ID/EX whose result the decoding instruction needs. A load to R0
  // never stalls. The bubble it inserts clears the condition next cycle.
  assign w_hz = valid_o & mem_sig_o[1] & (dest_o != 5'd0) &
                ((dest_o == w_rs) | (w_ctrl.uses_rt & (dest_o == w_rt)));

  // stall_o holds PC and IF/ID; a taken branch squashes the decode instead.
  assign stall_o  = w_hz & ~flush_i;
  assign w_bubble = rst | (~freeze_i & (flush_i | w_hz));

  always_ff @(posedge clk) begin
    if (w_bubble) begin
      valid_o   <= 1'b0;
      wb_en_o   <= 1'b0;
      mem_sig_o <= MEM_NONE;
      br_type_o <= BR_NONE;
      exe_cmd_o <= '0;
      val1_o    <= '0;
      val2_o    <= '0;
      st_val_o  <= '0;
      pc_o      <= '0;
      dest_o    <= '0;
      src1_o    <= '0;
      src2_o    <= '0;
    end else if (!freeze_i) begin
      valid_o   <= 1'b1;
      wb_en_o   <= w_ctrl.wb;
      mem_sig_o <= w_ctrl.mem;
      br_type_o <= w_ctrl.br;
      exe_cmd_o <= w_ctrl.cmd;
      val1_o    <= w_rs_val;
      val2_o    <= w_ctrl.is_imm ? w_imm_ext : w_rt_val;
      st_val_o  <= w_rt_val;
      pc_o      <= pc_i;
      dest_o    <= w_ctrl.is_imm ? w_rt : w_rd;
      src1_o    <= w_rs;
      src2_o    <= w_ctrl.uses_rt ? w_rt : 5'd0;
    end
  end

endmodule

// File: tb/tb_id_stage_pipe.sv
// Bench for id_stage_pipe: directed scenarios followed by random instruction
// streams, all checked against a behavioural model of the stage.
module tb_id_stage_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] instr_i;
  logic [31:0] pc_i;
  logic        freeze_i;
  logic        flush_i;
  logic        wb_en_i;
  logic [4:0]  wb_dest_i;
  logic [31:0] wb_data_i;
  logic        stall_o;
  logic        valid_o;
  logic        wb_en_o;
  logic [1:0]  mem_sig_o;
  logic [1:0]  br_type_o;
  logic [3:0]  exe_cmd_o;
  logic [31:0] val1_o;
  logic [31:0] val2_o;
  logic [31:0] st_val_o;
  logic [31:0] pc_o;
  logic [4:0]  dest_o;
  logic [4:0]  src1_o;
  logic [4:0]  src2_o;

  always #5 clk = ~clk;

  id_stage_pipe dut (
    .clk       (clk),
    .rst       (rst),
    .instr_i   (instr_i),
    .pc_i      (pc_i),
    .freeze_i  (freeze_i),
    .flush_i   (flush_i),
    .wb_en_i   (wb_en_i),
    .wb_dest_i (wb_dest_i),
    .wb_data_i (wb_data_i),
    .stall_o   (stall_o),
    .valid_o   (valid_o),
    .wb_en_o   (wb_en_o),
    .mem_sig_o (mem_sig_o),
    .br_type_o (br_type_o),
    .exe_cmd_o (exe_cmd_o),
    .val1_o    (val1_o),
    .val2_o    (val2_o),
    .st_val_o  (st_val_o),
    .pc_o      (pc_o),
    .dest_o    (dest_o),
    .src1_o    (src1_o),
    .src2_o    (src2_o)
  );

  typedef struct packed {
    logic        valid;
    logic        wb;
    logic [1:0]  mem;
    logic [1:0]  br;
    logic [3:0]  cmd;
    logic [31:0] val1;
    logic [31:0] val2;
    logic [31:0] st;
    logic [31:0] pc;
    logic [4:0]  dest;
    logic [4:0]  src1;
    logic [4:0]  src2;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        m_cur;
  logic [31:0] m_rf[32];
  int          n_cmp = 0;
  int          n_bad = 0;
  logic        last_stall;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic void m_reset_rf();
    for (int i = 0; i < 32; i++) m_rf[i] = 32'(i);
  endfunction

  // R0 is hardwired zero; anything else sees a same-cycle write first.
  function automatic logic [31:0] m_read(input logic [4:0] idx);
    if (idx == 5'd0) return 32'd0;
    if (wb_en_i && wb_dest_i == idx) return wb_data_i;
    return m_rf[idx];
  endfunction

  // Instruction semantics straight from the ISA table.
  function automatic void m_dec(input logic [5:0] op, output logic wb, output logic [1:0] mem,
                                output logic [1:0] br, output logic [3:0] cmd,
                                output logic imm, output logic urt);
    logic alu;
    alu = 0; wb = 0; mem = 0; br = 0; cmd = 0; imm = 0; urt = 0;
    case (op)
      6'd1:  begin alu = 1; cmd = 4'b0000; end
      6'd3:  begin alu = 1; cmd = 4'b0010; end
      6'd5:  begin alu = 1; cmd = 4'b0100; end
      6'd6:  begin alu = 1; cmd = 4'b0101; end
      6'd7:  begin alu = 1; cmd = 4'b0110; end
      6'd8:  begin alu = 1; cmd = 4'b0111; end
      6'd9:  begin alu = 1; cmd = 4'b1000; end
      6'd10: begin alu = 1; cmd = 4'b1000; end
      6'd11: begin alu = 1; cmd = 4'b1001; end
      6'd12: begin alu = 1; cmd = 4'b1010; end
      6'd32: begin wb = 1; cmd = 4'b0000; imm = 1; end
      6'd33: begin wb = 1; cmd = 4'b0010; imm = 1; end
      6'd36: begin wb = 1; mem = 2'b10; imm = 1; end
      6'd37: begin mem = 2'b01; imm = 1; urt = 1; end
      6'd40: begin br = 2'b01; imm = 1; end
      6'd41: begin br = 2'b10; imm = 1; urt = 1; end
      6'd42: begin br = 2'b11; imm = 1; end
      default: ;
    endcase
    if (alu) begin wb = 1; urt = 1; end
  endfunction

  // One clock: check the combinational stall, predict the ID/EX contents,
  // then compare every registered output after the edge.
  task automatic step();
    exp_t nxt;
    logic wb, imm, urt, hz, exp_stall;
    logic [1:0] mem, br;
    logic [3:0] cmd;
    logic [4:0] rs, rt, rd;
    exp_t got;
    @(negedge clk);
    rs = instr_i[25:21];
    rt = instr_i[20:16];
    rd = instr_i[15:11];
    m_dec(instr_i[31:26], wb, mem, br, cmd, imm, urt);
    hz = m_cur.valid && m_cur.mem == 2'b10 && m_cur.dest != 0 &&
         (m_cur.dest == rs || (urt && m_cur.dest == rt));
    exp_stall = hz && !flush_i;
    last_stall = stall_o;
    check("stall", 32'(stall_o), 32'(exp_stall));
    nxt = '0;
    if (rst) nxt = '0;
    else if (freeze_i) nxt = m_cur;
    else if (flush_i || hz) nxt = '0;
    else begin
      nxt.valid = 1;
      nxt.wb    = wb;
      nxt.mem   = mem;
      nxt.br    = br;
      nxt.cmd   = cmd;
      nxt.val1  = m_read(rs);
      nxt.st    = m_read(rt);
      nxt.val2  = imm ? {{16{instr_i[15]}}, instr_i[15:0]} : m_read(rt);
      nxt.pc    = pc_i;
      nxt.dest  = imm ? rt : rd;
      nxt.src1  = rs;
      nxt.src2  = urt ? rt : 5'd0;
    end
    exp_q.push_back(nxt);
    if (rst) m_reset_rf();
    else if (wb_en_i && wb_dest_i != 0) m_rf[wb_dest_i] = wb_data_i;
    @(posedge clk);
    #1;
    m_cur = exp_q.pop_front();
    got = '{valid_o, wb_en_o, mem_sig_o, br_type_o, exe_cmd_o, val1_o, val2_o, st_val_o,
            pc_o, dest_o, src1_o, src2_o};
    check("valid", 32'(got.valid), 32'(m_cur.valid));
    check("wb_en", 32'(got.wb), 32'(m_cur.wb));
    check("mem_sig", 32'(got.mem), 32'(m_cur.mem));
    check("br_type", 32'(got.br), 32'(m_cur.br));
    check("exe_cmd", 32'(got.cmd), 32'(m_cur.cmd));
    check("val1", got.val1, m_cur.val1);
    check("val2", got.val2, m_cur.val2);
    check("st_val", got.st, m_cur.st);
    check("pc", got.pc, m_cur.pc);
    check("dest", 32'(got.dest), 32'(m_cur.dest));
    check("src1", 32'(got.src1), 32'(m_cur.src1));
    check("src2", 32'(got.src2), 32'(m_cur.src2));
  endtask

  task automatic drive(input logic [31:0] instr, input logic [31:0] pc, input logic frz,
                       input logic fl, input logic we, input logic [4:0] wd,
                       input logic [31:0] wdata);
    instr_i   = instr;
    pc_i      = pc;
    freeze_i  = frz;
    flush_i   = fl;
    wb_en_i   = we;
    wb_dest_i = wd;
    wb_data_i = wdata;
  endtask

  function automatic logic [31:0] r_ins(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [4:0] rd);
    return {op, rs, rt, rd, 11'd0};
  endfunction

  function automatic logic [31:0] i_ins(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  logic [5:0] op_pool [20] = '{6'd0, 6'd1, 6'd3, 6'd5, 6'd6, 6'd7, 6'd8, 6'd9, 6'd10, 6'd11,
                               6'd12, 6'd32, 6'd33, 6'd36, 6'd37, 6'd40, 6'd41, 6'd42,
                               6'd2, 6'd50};

  initial begin
    m_cur = '0;
    m_reset_rf();
    rst = 1'b1;
    drive(32'd0, 32'd0, 0, 0, 0, 5'd0, 32'd0);
    step();
    step();
    check("rst_valid", 32'(valid_o), 32'd0);
    check("rst_pc", pc_o, 32'd0);
    rst = 1'b0;

    // ADD R3,R1,R2
    drive(32'h0422_1800, 32'h100, 0, 0, 0, 5'd0, 32'd0);
    step();
    check("add_valid", 32'(valid_o), 32'd1);
    check("add_val1", val1_o, 32'd1);
    check("add_val2", val2_o, 32'd2);
    check("add_dest", 32'(dest_o), 32'd3);
    check("add_cmd", 32'(exe_cmd_o), 32'd0);
    check("add_wb", 32'(wb_en_o), 32'd1);

    // ADDI R4,R1,-1 while WB writes R1 = 0xAA
    drive(i_ins(6'd32, 5'd1, 5'd4, 16'hFFFF), 32'h104, 0, 0, 1, 5'd1, 32'hAA);
    step();
    check("byp_val1", val1_o, 32'hAA);
    check("byp_val2", val2_o, 32'hFFFF_FFFF);
    check("byp_dest", 32'(dest_o), 32'd4);

    // Load-use: LD R5 then ADD R6,R5,R2
    drive(i_ins(6'd36, 5'd0, 5'd5, 16'h0010), 32'h108, 0, 0, 0, 5'd0, 32'd0);
    step();
    drive(r_ins(6'd1, 5'd5, 5'd2, 5'd6), 32'h10C, 0, 0, 0, 5'd0, 32'd0);
    step();
    check("lu_stall", 32'(last_stall), 32'd1);
    check("lu_bubble", 32'(valid_o), 32'd0);
    step();
    check("lu_stall_end", 32'(last_stall), 32'd0);
    check("lu_issue_dest", 32'(dest_o), 32'd6);
    check("lu_issue_valid", 32'(valid_o), 32'd1);

    // Same hazard, but EXE flushes
    drive(i_ins(6'd36, 5'd0, 5'd5, 16'h0010), 32'h110, 0, 0, 0, 5'd0, 32'd0);
    step();
    drive(r_ins(6'd1, 5'd5, 5'd2, 5'd6), 32'h114, 0, 1, 0, 5'd0, 32'd0);
    step();
    check("fl_stall", 32'(last_stall), 32'd0);
    check("fl_bubble", 32'(valid_o), 32'd0);
    flush_i = 1'b0;
    step();
    check("fl_no_restall", 32'(last_stall), 32'd0);

    // Freeze for 3 cycles while WB writes R7
    drive(r_ins(6'd1, 5'd7, 5'd1, 5'd3), 32'h118, 0, 0, 0, 5'd0, 32'd0);
    step();
    for (int i = 0; i < 3; i++) begin
      drive(r_ins(6'd3, 5'd2, 5'd2, 5'd9), 32'h200 + 32'(i), 1, 0, 1, 5'd7, 32'h55);
      step();
    end
    check("frz_val1_held", val1_o, 32'd7);
    check("frz_pc_held", pc_o, 32'h118);
    drive(r_ins(6'd1, 5'd7, 5'd1, 5'd3), 32'h11C, 0, 0, 0, 5'd0, 32'd0);
    step();
    check("frz_wb_landed", val1_o, 32'h55);

    // R0 hardwired: write R0 = 7 while reading it
    drive(r_ins(6'd1, 5'd0, 5'd0, 5'd9), 32'h120, 0, 0, 1, 5'd0, 32'd7);
    step();
    check("r0_byp_val1", val1_o, 32'd0);
    wb_en_i = 1'b0;
    step();
    check("r0_read_val2", val2_o, 32'd0);
    drive(i_ins(6'd36, 5'd1, 5'd0, 16'h0004), 32'h124, 0, 0, 0, 5'd0, 32'd0);
    step();
    drive(r_ins(6'd1, 5'd0, 5'd0, 5'd6), 32'h128, 0, 0, 0, 5'd0, 32'd0);
    step();
    check("r0_ld_no_stall", 32'(last_stall), 32'd0);

    // Random streams with small register indices to provoke hazards/bypass
    for (int n = 0; n < 500; n++) begin
      logic [5:0] op;
      op = ($urandom_range(0, 3) == 0) ? 6'd36 : op_pool[$urandom_range(0, 19)];
      rst = ($urandom_range(0, 199) == 0);
      drive({op, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
             5'($urandom_range(0, 7)), 11'($urandom())},
            $urandom(), ($urandom_range(0, 9) == 0), ($urandom_range(0, 9) == 0),
            ($urandom_range(0, 1) == 1), 5'($urandom_range(0, 7)), $urandom());
      step();
    end
    rst = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/id_stage_pipe.md
Name: id_stage_pipe

Overview:
- Parametrised instruction-decode stage with its own ID/EX pipeline register. Generalises the single-width decode stage.
- Adds generic data width and register count, a hardwired-zero R0 option, write-through bypass from WB, load-use hazard detection with stall, EXE-driven flush, external freeze, and source-register outputs for a forwarding unit.
- Sits between the IF/ID register and EXE; WB feeds its register-file write port.

Parameters:
- XLEN, 32, datapath width; immediate is sign-extended from 16 bits to XLEN.
- NREGS, 32, register count (at most 32); unused high indices read 0 and ignore writes.
- R0_ZERO, 1, when 1 R0 reads 0 and writes to it are dropped.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- instr_i  in  32  instruction: opcode[31:26], rs[25:21], rt[20:16], rd[15:11], imm[15:0]
- pc_i  in  XLEN  PC of instr_i
- freeze_i  in  1  downstream stall; hold ID/EX register and stall_o
- flush_i  in  1  branch taken in EXE; squash the current decode
- wb_en_i  in  1  register write enable
- wb_dest_i  in  5  write index
- wb_data_i  in  XLEN  write data
- stall_o  out  1  combinational; holds PC and IF/ID register
- valid_o  out  1  ID/EX holds a real instruction
- wb_en_o  out  1
- mem_sig_o  out  2  bit1 = read, bit0 = write
- br_type_o  out  2  00 none, 01 BEZ, 10 BNE, 11 JMP
- exe_cmd_o  out  4
- val1_o  out  XLEN  rs value
- val2_o  out  XLEN  rt value, or sign-extended imm when is_imm
- st_val_o  out  XLEN  rt value (store data / BNE operand)
- pc_o  out  XLEN
- dest_o  out  5  rt if is_imm, else rd
- src1_o, src2_o  out  5  rs; rt when used, else 0

Behaviour:
- Reset: every output register 0, including valid_o.
- Register file: entry i initialises to i, except R0 which is 0 when R0_ZERO. Written at posedge clk when wb_en_i is set.
- Bypass: a read whose index equals wb_dest_i while wb_en_i is set returns wb_data_i in the same cycle. Not applied to R0 when R0_ZERO.
- Decode (package table): NOP/unknown all 0; ADD 0000, SUB 0010, AND 0100, OR 0101, NOR 0110, XOR 0111, SLA/SLL 1000, SRA 1001, SRL 1010.
  - ADDI/SUBI: cmd 0000/0010, imm.
  - LD: wb, mem 10, imm.
  - ST: mem 01, imm.
  - BEZ/BNE/JMP: br 01/10/11, imm.
- uses_rt: (R-type and opcode ≠ 0) or ST or BNE.
- Hazard: hz = valid_o & mem_sig_o[1] & dest_o ≠ 0 & (dest_o == rs | (uses_rt & dest_o == rt)).
- stall_o = hz & ~flush_i. Freeze_i does not drive stall_o; the IF/ID freeze path is external.
- Register update priority, per cycle:
  1. rst: clear.
  2. freeze_i: hold.
  3. flush_i or hz: bubble (valid 0, all control and data 0).
  4. otherwise: load decoded instruction, valid_o = 1.
- Latency: one cycle from instr_i to outputs.
- Stall length: a load-use stall lasts exactly one cycle, because the bubble clears the hazard.
- Freeze with write: a WB write during freeze_i still updates the register file.

Decomposition:
- Package id_pkg: opcode constants, EXE_CMD codes, BR_* and MEM_* codes, struct ctrl_t {wb, mem[1:0], br[1:0], cmd[3:0], is_imm, uses_rt}.
- Sub-module regfile_bypass (parametrised XLEN/NREGS/R0_ZERO, 2R1W).
- Decoder is a function in id_pkg.

Test Plan:
- Reset, then ADD R3,R1,R2 (0x04221800) -> next cycle valid 1, val1 1, val2 2, dest 3, cmd 0000, wb 1.
- WB writes R1 = 0xAA while ADDI R4,R1,-1 decodes -> val1 0xAA, val2 0xFFFFFFFF, dest 4.
- LD R5 in ID/EX, ADD R6,R5,R2 in decode -> stall_o 1 for one cycle, bubble (valid 0), then ADD issues.
- Same hazard with flush_i = 1 -> stall_o 0, bubble, no second stall.
- freeze_i held 3 cycles -> all outputs unchanged; a WB write lands and is visible after release.
- R0_ZERO = 1: write R0 = 7, read R0 -> 0. Also LD R0 followed by a dependent instruction -> no stall.
